// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and address legality helper for the
// register-file port arbiter and its sub-blocks.
package regfile_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(DEPTH);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: the pointer names the port that wins a tie
// and is moved past the last winner when update is pulsed.
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       update,
  input  logic       update_port,
  output logic [1:0] grant
);

  logic ptr;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~update_port;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (enable && !Rst) begin
      if (req == 2'b11) begin
        grant[ptr] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a 2-read/1-write register file between two requesters; each request
// is an atomic read-read-(write) transaction answered on a valid/ready channel.
module regfile_port_arbiter
  import regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_raddr1,
  input  logic [ADDR_W-1:0] req0_raddr2,
  input  logic [ADDR_W-1:0] req0_waddr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_raddr1,
  input  logic [ADDR_W-1:0] req1_raddr2,
  input  logic [ADDR_W-1:0] req1_waddr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data1,
  output logic [DATA_W-1:0] rsp0_data2,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data1,
  output logic [DATA_W-1:0] rsp1_data2,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              rf_en,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2
);

  state_t            state, state_next;
  logic [1:0]        grant;
  logic              held_we;
  logic              held_port;
  logic [ADDR_W-1:0] held_raddr1, held_raddr2, held_waddr;
  logic [DATA_W-1:0] held_wdata;
  logic              resp_active;
  logic              held_err;
  logic [DATA_W-1:0] resp_data1, resp_data2;
  logic              owner_ready;

  rr_arbiter2 u_arb (
    .Clk         (Clk),
    .Rst         (Rst),
    .req         ({req1_valid, req0_valid}),
    .enable      (state == IDLE),
    .update      (state == ISSUE),
    .update_port (held_port),
    .grant       (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      held_we     <= 1'b0;
      held_port   <= 1'b0;
      held_raddr1 <= '0;
      held_raddr2 <= '0;
      held_waddr  <= '0;
      held_wdata  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant != 2'b00) begin
        held_port   <= grant[1];
        held_we     <= grant[1] ? req1_we     : req0_we;
        held_raddr1 <= grant[1] ? req1_raddr1 : req0_raddr1;
        held_raddr2 <= grant[1] ? req1_raddr2 : req0_raddr2;
        held_waddr  <= grant[1] ? req1_waddr  : req0_waddr;
        held_wdata  <= grant[1] ? req1_wdata  : req0_wdata;
      end
    end
  end

  assign owner_ready = held_port ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant != 2'b00) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (owner_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Held addresses stay on the file through RESP so its registered read data remains stable.
  assign rf_read_reg1  = held_raddr1;
  assign rf_read_reg2  = held_raddr2;
  assign rf_write_reg  = held_waddr;
  assign rf_write_data = held_wdata;
  assign rf_en         = (state == ISSUE) && !Rst;
  assign rf_reg_write  = rf_en && held_we && addr_ok(held_waddr);

  assign resp_active = (state == RESP) && !Rst;
  assign held_err    = !addr_ok(held_raddr1) || !addr_ok(held_raddr2) ||
                       (held_we && !addr_ok(held_waddr));
  assign resp_data1  = (resp_active && addr_ok(held_raddr1)) ? rf_read_data1 : '0;
  assign resp_data2  = (resp_active && addr_ok(held_raddr2)) ? rf_read_data2 : '0;

  assign rsp0_valid = resp_active && !held_port;
  assign rsp1_valid = resp_active && held_port;
  assign rsp0_data1 = rsp0_valid ? resp_data1 : '0;
  assign rsp0_data2 = rsp0_valid ? resp_data2 : '0;
  assign rsp1_data1 = rsp1_valid ? resp_data1 : '0;
  assign rsp1_data2 = rsp1_valid ? resp_data2 : '0;
  assign rsp0_err   = rsp0_valid && held_err;
  assign rsp1_err   = rsp1_valid && held_err;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a write-first registered
// register file model attached to the rf_* interface.
module tb_regfile_port_arbiter;
  import regfile_pkg::*;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              req0_valid, req0_ready, req0_we;
  logic [ADDR_W-1:0] req0_raddr1, req0_raddr2, req0_waddr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [ADDR_W-1:0] req1_raddr1, req1_raddr2, req1_waddr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid, rsp0_ready, rsp0_err;
  logic [DATA_W-1:0] rsp0_data1, rsp0_data2;
  logic              rsp1_valid, rsp1_ready, rsp1_err;
  logic [DATA_W-1:0] rsp1_data1, rsp1_data2;
  logic [ADDR_W-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_reg_write, rf_en;
  logic [DATA_W-1:0] rf_read_data1, rf_read_data2;

  logic [DATA_W-1:0] mem [DEPTH];
  int checks = 0;
  int passed = 0;
  int port;

  regfile_port_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_raddr1(req0_raddr1), .req0_raddr2(req0_raddr2),
    .req0_waddr(req0_waddr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_raddr1(req1_raddr1), .req1_raddr2(req1_raddr2),
    .req1_waddr(req1_waddr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data1(rsp0_data1), .rsp0_data2(rsp0_data2), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data1(rsp1_data1), .rsp1_data2(rsp1_data2), .rsp1_err(rsp1_err),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_reg_write(rf_reg_write), .rf_en(rf_en),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  always #5 Clk = ~Clk;

  // Register file: reads are registered every edge and see a same-cycle write.
  always @(posedge Clk) begin
    if (rf_en && rf_reg_write) mem[rf_write_reg[5:0]] <= rf_write_data;
    rf_read_data1 <= (rf_en && rf_reg_write && rf_write_reg == rf_read_reg1)
                     ? rf_write_data : mem[rf_read_reg1[5:0]];
    rf_read_data2 <= (rf_en && rf_reg_write && rf_write_reg == rf_read_reg2)
                     ? rf_write_data : mem[rf_read_reg2[5:0]];
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_waddr = wa; req0_wdata = wd;
      req0_raddr1 = r1; req0_raddr2 = r2;
    end else begin
      req1_valid = v; req1_we = we; req1_waddr = wa; req1_wdata = wd;
      req1_raddr1 = r1; req1_raddr2 = r2;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Called at a negedge with requests driven; returns the granted port or -1.
  task automatic wait_grant(output int p);
    p = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        p = req1_ready ? 1 : 0;
        return;
      end
      @(negedge Clk);
    end
    check_output("grant_timeout", 64'd1, 64'd0);
  endtask

  // Called 1 unit after the negedge of the grant cycle.
  task automatic finish_txn(input int p, input logic exp_wr, input logic [63:0] exp1,
                            input logic [63:0] exp2, input logic exp_err);
    @(negedge Clk);
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    check_output("issue_rf_en", rf_en, 1'b1);
    check_output("issue_reg_write", rf_reg_write, exp_wr);
    @(negedge Clk);
    #1;
    if (p == 0) begin
      check_output("rsp0_valid", rsp0_valid, 1'b1);
      check_output("rsp0_data1", rsp0_data1, exp1);
      check_output("rsp0_data2", rsp0_data2, exp2);
      check_output("rsp0_err", rsp0_err, exp_err);
      check_output("rsp1_idle", rsp1_valid, 1'b0);
      rsp0_ready = 1'b1;
    end else begin
      check_output("rsp1_valid", rsp1_valid, 1'b1);
      check_output("rsp1_data1", rsp1_data1, exp1);
      check_output("rsp1_data2", rsp1_data2, exp2);
      check_output("rsp1_err", rsp1_err, exp_err);
      check_output("rsp0_idle", rsp0_valid, 1'b0);
      rsp1_ready = 1'b1;
    end
    @(negedge Clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    check_output("rsp_dropped", {rsp1_valid, rsp0_valid}, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    Rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 9'd0, 64'd0, 9'd0, 9'd0);
    set_req(1, 1'b0, 1'b0, 9'd0, 64'd0, 9'd0, 9'd0);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    check_output("reset_ready0", req0_ready, 1'b0);
    check_output("reset_rf_en", rf_en, 1'b0);
    check_output("reset_reg_write", rf_reg_write, 1'b0);
    check_output("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check_output("reset_rf_addr", {rf_read_reg1, rf_read_reg2, rf_write_reg}, 27'd0);
    check_output("reset_rf_wdata", rf_write_data, 64'd0);
    check_output("reset_rsp_data", rsp0_data1, 64'd0);
    check_output("reset_rsp_err", {rsp1_err, rsp0_err}, 2'b00);

    // Write-first read of the register written by the same transaction.
    @(negedge Clk);
    Rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 9'd5, 64'hDEAD_BEEF, 9'd5, 9'd0);
    wait_grant(port);
    check_output("t1_grant", port, 0);
    check_output("t1_ready1", req1_ready, 1'b0);
    check_output("t1_write_reg", rf_write_reg, 9'd0);
    finish_txn(0, 1'b1, 64'hDEAD_BEEF, 64'd0, 1'b0);

    // Simultaneous requests after reset: port 0 first, then port 1 sees its write.
    do_reset();
    set_req(0, 1'b1, 1'b1, 9'd7, 64'h1234, 9'd7, 9'd5);
    set_req(1, 1'b1, 1'b0, 9'd0, 64'd0, 9'd7, 9'd5);
    wait_grant(port);
    check_output("t2_first", port, 0);
    finish_txn(0, 1'b1, 64'h1234, 64'hDEAD_BEEF, 1'b0);
    wait_grant(port);
    check_output("t2_second", port, 1);
    finish_txn(1, 1'b0, 64'h1234, 64'hDEAD_BEEF, 1'b0);

    // Sustained contention alternates grants.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b0, 9'd0, 64'd0, 9'd7, 9'd5);
      set_req(1, 1'b1, 1'b0, 9'd0, 64'd0, 9'd5, 9'd0);
      wait_grant(port);
      check_output("t3_alternate", port, k % 2);
      if (port == 1) finish_txn(1, 1'b0, 64'hDEAD_BEEF, 64'd0, 1'b0);
      else           finish_txn(0, 1'b0, 64'h1234, 64'hDEAD_BEEF, 1'b0);
    end
    set_req(0, 1'b0, 1'b0, 9'd0, 64'd0, 9'd0, 9'd0);
    set_req(1, 1'b0, 1'b0, 9'd0, 64'd0, 9'd0, 9'd0);

    // Out-of-range write and reads: no write, error flagged, data1 forced to zero.
    set_req(0, 1'b1, 1'b1, 9'd3, 64'h3333, 9'd3, 9'd6);
    wait_grant(port);
    finish_txn(0, 1'b1, 64'h3333, 64'd0, 1'b0);
    set_req(1, 1'b1, 1'b1, 9'd70, 64'hAAAA, 9'd64, 9'd3);
    wait_grant(port);
    check_output("t4_grant", port, 1);
    finish_txn(1, 1'b0, 64'd0, 64'h3333, 1'b1);
    set_req(0, 1'b1, 1'b0, 9'd0, 64'd0, 9'd6, 9'd3);
    wait_grant(port);
    finish_txn(0, 1'b0, 64'd0, 64'h3333, 1'b0);

    // Response held by back-pressure while port 1 waits.
    set_req(0, 1'b1, 1'b0, 9'd0, 64'd0, 9'd7, 9'd3);
    wait_grant(port);
    check_output("t5_grant", port, 0);
    @(negedge Clk);
    req0_valid = 1'b0;
    set_req(1, 1'b1, 1'b0, 9'd0, 64'd0, 9'd5, 9'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      #1;
      check_output("t5_hold_valid", rsp0_valid, 1'b1);
      check_output("t5_hold_data", {rsp0_data1, rsp0_data2}, {64'h1234, 64'h3333});
      check_output("t5_ready1_low", req1_ready, 1'b0);
    end
    rsp0_ready = 1'b1;
    @(negedge Clk);
    rsp0_ready = 1'b0;
    #1;
    check_output("t5_ready1_after", req1_ready, 1'b1);
    finish_txn(1, 1'b0, 64'hDEAD_BEEF, 64'h3333, 1'b0);

    // Reset during ISSUE suppresses the write and drops the transaction.
    set_req(0, 1'b1, 1'b1, 9'd9, 64'hFF, 9'd9, 9'd9);
    wait_grant(port);
    @(negedge Clk);
    req0_valid = 1'b0;
    Rst = 1'b1;
    #1;
    check_output("t6_rf_en", rf_en, 1'b0);
    check_output("t6_reg_write", rf_reg_write, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 9'd0, 64'd0, 9'd9, 9'd0);
    #1;
    check_output("t6_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check_output("t6_idle_ready", req0_ready, 1'b1);
    wait_grant(port);
    finish_txn(0, 1'b0, 64'd0, 64'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
